muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit that implements the MULT/MULTU/DIV/DIVU operations (signed and unsigned), which the combinational ALU only stubs out. It sits beside the ALU in the execute stage. It accepts one operation at a time through a start/busy/valid handshake and produces HI/LO results. MULT gives HI:LO as the double-width product; DIV gives LO as the quotient and HI as the remainder.

---
 rtl/muldiv_unit.sv | 171 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit for the execute stage.
//
// Handles MULT/MULTU (shift-add, 2*WIDTH product on hi:lo) and DIV/DIVU
// (restoring, quotient on lo, remainder on hi). Signed ops run on operand
// magnitudes, and the sign is fixed up once at the end. Every operation
// takes the same number of cycles, whatever the op or operand values.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        request pulse, sampled only while busy=0
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b         operand A / dividend, operand B / divisor
//   flush        cancels an in-flight operation (no valid, results held)
//   busy         operation in progress
//   valid        one-cycle pulse when hi/lo are updated
//   hi, lo       product high/low, or remainder/quotient
//   div_by_zero  last completed op was a DIV/DIVU with b=0
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    // Operation context latched at accept time
    typedef struct packed {
        logic [1:0] op;
        logic       sa;   // dividend / multiplicand A negative (signed ops only)
        logic       sb;   // divisor / operand B negative (signed ops only)
    } req_t;

    state_t                 state, state_nx;
    req_t                   req;
    logic [CNT_W-1:0]       cnt;
    logic [WIDTH-1:0]       mag_a;   // multiplier (shifts right) or dividend/quotient (shifts left)
    logic [WIDTH-1:0]       mag_b;   // multiplicand or divisor
    logic [WIDTH-1:0]       a_raw;   // original dividend, returned on hi for divide by zero
    logic [2*WIDTH-1:0]     acc;

    logic                   is_signed, is_div, a_neg, b_neg, div0;
    logic [WIDTH:0]         mul_sum;
    logic [2*WIDTH-1:0]     mul_nx;
    logic [WIDTH:0]         r_sh;
    logic [WIDTH+1:0]       diff;
    logic                   qbit;
    logic [2*WIDTH-1:0]     prod;
    logic [WIDTH-1:0]       quo, rem;

    assign busy = (state != IDLE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start && !flush) state_nx = RUN;
            RUN: begin
                if (flush)                    state_nx = IDLE;
                else if (cnt == CNT_W'(1))    state_nx = FIN;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- iteration datapath ----------------
    always_comb begin
        is_signed = ~req.op[0];
        is_div    = req.op[1];
        a_neg     = ~op[0] & a[WIDTH-1];
        b_neg     = ~op[0] & b[WIDTH-1];

        // Shift-add: add into the upper half with carry, then shift the
        // whole accumulator right one place.
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mag_a[0] ? {1'b0, mag_b} : '0);
        mul_nx  = {mul_sum, acc[WIDTH-1:1]};

        // Restoring divide: partial remainder lives in acc[2W-2:W-1]. One
        // extra bit is needed for the shifted remainder, one for the borrow.
        r_sh = {acc[2*WIDTH-2:WIDTH-1], mag_a[WIDTH-1]};
        diff = {1'b0, r_sh} - {2'b0, mag_b};
        qbit = ~diff[WIDTH+1];

        // Sign correction for the result
        div0 = (mag_b == '0);
        prod = acc;
        if (is_signed && (req.sa ^ req.sb)) prod = -acc;
        quo = mag_a;
        rem = acc[2*WIDTH-2:WIDTH-1];
        if (is_signed && (req.sa ^ req.sb)) quo = -mag_a;
        if (is_signed && req.sa)            rem = -acc[2*WIDTH-2:WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req         <= '0;
            cnt         <= '0;
            mag_a       <= '0;
            mag_b       <= '0;
            a_raw       <= '0;
            acc         <= '0;
            hi          <= '0;
            lo          <= '0;
            valid       <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        req   <= '{op: op, sa: a_neg, sb: b_neg};
                        mag_a <= a_neg ? -a : a;
                        mag_b <= b_neg ? -b : b;
                        a_raw <= a;
                        acc   <= '0;
                        cnt   <= CNT_W'(WIDTH);
                    end
                end
                RUN: begin
                    if (!flush) begin
                        cnt <= cnt - CNT_W'(1);
                        if (is_div) begin
                            acc[2*WIDTH-1:WIDTH-1] <= qbit ? diff[WIDTH:0] : r_sh;
                            mag_a <= {mag_a[WIDTH-2:0], qbit};
                        end else begin
                            acc   <= mul_nx;
                            mag_a <= mag_a >> 1;
                        end
                    end
                end
                FIN: begin
                    if (!flush) begin
                        valid <= 1'b1;
                        if (!is_div) begin
                            {hi, lo}    <= prod;
                            div_by_zero <= 1'b0;
                        end else if (div0) begin
                            hi          <= a_raw;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end else begin
                            hi          <= rem;
                            lo          <= quo;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit (WIDTH=32) with hand-computed expectations.
module tb_muldiv_unit;

    logic        clk, rst_n, start, flush;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, valid, div_by_zero;
    logic [31:0] hi, lo;

    int ntests = 0;
    int nfail  = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .valid(valid), .hi(hi), .lo(lo),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op and wait for valid; lat = edges from accept to valid,
    // bcnt = samples with busy high. Leaves us in the valid cycle.
    task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int bcnt);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bcnt = busy ? 1 : 0;
        lat  = 0;
        while (!valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    int lat, bcnt, nv, vcyc;
    logic [31:0] vhi, vlo;

    initial begin
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_hilo",  {hi, lo}, 64'd0);
        chk("rst_dbz",   64'(div_by_zero), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        // 1: MULTU max*max, latency and busy length
        run(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
        chk("multu_max_lat",  64'(lat), 64'd33);
        chk("multu_max_busy", 64'(bcnt), 64'd33);
        chk("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);

        // 2: signed multiply
        run(MULT, 32'hFFFFFFFD, 32'd5, lat, bcnt);
        chk("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
        chk("mult_neg_b2b_lat", 64'(lat), 64'd33);
        run(MULT, 32'h80000000, 32'h80000000, lat, bcnt);
        chk("mult_min", {hi, lo}, 64'h40000000_00000000);

        // 3: divides
        run(DIV, 32'hFFFFFFF9, 32'd2, lat, bcnt);
        chk("div_neg7_2", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run(DIVU, 32'd7, 32'd2, lat, bcnt);
        chk("divu_7_2", {hi, lo}, 64'h00000001_00000003);
        run(DIV, 32'd7, 32'hFFFFFFFE, lat, bcnt);
        chk("div_7_neg2", {hi, lo}, 64'h00000001_FFFFFFFD);
        chk("div_lat", 64'(lat), 64'd33);

        // 4: overflow and divide by zero
        run(DIV, 32'h80000000, 32'hFFFFFFFF, lat, bcnt);
        chk("div_ovf", {hi, lo}, 64'h00000000_80000000);
        chk("div_ovf_dbz", 64'(div_by_zero), 64'd0);
        run(DIVU, 32'd5, 32'd0, lat, bcnt);
        chk("divu_zero", {hi, lo}, 64'h00000005_FFFFFFFF);
        chk("divu_zero_dbz", 64'(div_by_zero), 64'd1);
        chk("divu_zero_lat", 64'(lat), 64'd33);
        run(MULTU, 32'd2, 32'd3, lat, bcnt);
        chk("multu_2_3", {hi, lo}, 64'h00000000_00000006);
        chk("multu_dbz_clr", 64'(div_by_zero), 64'd0);
        run(DIV, 32'hFFFFFFF9, 32'd0, lat, bcnt);
        chk("div_neg_zero", {hi, lo}, 64'hFFFFFFF9_FFFFFFFF);
        chk("div_neg_zero_dbz", 64'(div_by_zero), 64'd1);

        // 5a: start while busy is ignored
        @(negedge clk);
        op = DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nv = 0; vcyc = 0; vhi = '0; vlo = '0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            start = (i == 10);
            if (i == 10) begin op = MULTU; a = 32'd3; b = 32'd3; end
            @(posedge clk); #1;
            if (valid) begin nv++; vcyc = i; vhi = hi; vlo = lo; end
        end
        start = 1'b0;
        chk("ign_nvalid", 64'(nv), 64'd1);
        chk("ign_lat", 64'(vcyc), 64'd33);
        chk("ign_result", {vhi, vlo}, 64'h00000002_0000000E);

        // 5b: flush mid-run
        @(negedge clk);
        op = MULTU; a = 32'd6; b = 32'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy",  64'(busy), 64'd0);
        chk("flush_valid", 64'(valid), 64'd0);
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid) nv++;
        end
        chk("flush_nvalid", 64'(nv), 64'd0);
        chk("flush_hold", {hi, lo}, 64'h00000002_0000000E);

        // 6: async reset mid-run (after a result that leaves hi/lo/dbz nonzero)
        run(DIVU, 32'd9, 32'd0, lat, bcnt);
        chk("pre_rst_dbz", 64'(div_by_zero), 64'd1);
        @(negedge clk);
        op = MULTU; a = 32'd5; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",  64'(busy), 64'd0);
        chk("arst_valid", 64'(valid), 64'd0);
        chk("arst_hilo",  {hi, lo}, 64'd0);
        chk("arst_dbz",   64'(div_by_zero), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        run(MULTU, 32'd6, 32'd7, lat, bcnt);
        chk("post_rst_lat", 64'(lat), 64'd33);
        chk("post_rst", {hi, lo}, 64'h00000000_0000002A);

        @(posedge clk); #1;
        chk("valid_one_cycle", 64'(valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
